// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C memory target: the slave FSM state encoding,
// bus-level ACK/NACK levels and the default 7-bit bus address.
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    // Level seen on sda during the acknowledge slot.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IDLE_WAIT
    } slave_state_t;

endpackage

// File: rtl/i2c_mem_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_mem_slave_if
// Groups the I2C clock input and the memory-side status/strobe outputs of the
// I2C memory target. The open-drain sda pin stays a plain inout port of the
// target so tristate resolution happens at the pad boundary.
//
// Signals:
//   scl       I2C clock from the bus (never driven by the target)
//   busy      high from address match until STOP/START/mismatch
//   wr_strobe one-cycle pulse per byte committed to memory
//   wr_addr   pointer of the committed byte
//   wr_data   committed byte
//   rd_strobe one-cycle pulse when a byte is loaded for transmission
//   ack_err   sticky: master ACKed past the pointer wrap; cleared on START
//   state     current slave FSM state (debug visibility)
//
// Handshake: wr_strobe and rd_strobe are valid-only pulses with no ready;
// wr_addr/wr_data are meaningful only in the cycle wr_strobe is high and
// hold their last value otherwise. The consumer cannot stall the target.
// -----------------------------------------------------------------------------
interface i2c_mem_slave_if;
    import i2c_pkg::*;

    logic         scl;
    logic         busy;
    logic         wr_strobe;
    logic [7:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         rd_strobe;
    logic         ack_err;
    slave_state_t state;

    modport slave (
        input  scl,
        output busy, wr_strobe, wr_addr, wr_data, rd_strobe, ack_err, state
    );

    modport master (
        output scl,
        input  busy, wr_strobe, wr_addr, wr_data, rd_strobe, ack_err, state
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings scl/sda into the clk domain and produces single-cycle bus events.
// scl: 2-flop synchroniser. sda: 2-flop synchroniser followed by a
// SDA_DELAY-stage delay line, giving hold margin against scl.
// All event outputs are registered: scl events appear 3 cycles after the pin
// changes, sda-derived events 3+SDA_DELAY cycles after.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   scl, sda   raw bus pins
//   scl_rise   pulse on synchronised scl rising edge
//   scl_fall   pulse on synchronised scl falling edge
//   start      delayed sda falls while scl high (this and previous cycle)
//   stop       delayed sda rises while scl high (this and previous cycle)
//   sda_s      delayed sda, aligned with the event pulses
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SDA_DELAY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       sda_dly [SDA_DELAY];
    logic       scl_prev;
    logic       sda_prev;
    logic       sda_tap;

    assign sda_tap = sda_dly[SDA_DELAY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the idle-bus level so no spurious events follow reset.
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            for (int i = 0; i < SDA_DELAY; i++) sda_dly[i] <= 1'b1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda_s    <= 1'b1;
        end else begin
            scl_sync   <= {scl_sync[0], scl};
            sda_sync   <= {sda_sync[0], sda};
            sda_dly[0] <= sda_sync[1];
            for (int i = 1; i < SDA_DELAY; i++) sda_dly[i] <= sda_dly[i-1];
            scl_prev   <= scl_sync[1];
            sda_prev   <= sda_tap;
            scl_rise   <= scl_sync[1] & ~scl_prev;
            scl_fall   <= ~scl_sync[1] & scl_prev;
            start      <= scl_sync[1] & scl_prev & sda_prev & ~sda_tap;
            stop       <= scl_sync[1] & scl_prev & ~sda_prev & sda_tap;
            sda_s      <= sda_tap;
        end
    end

endmodule

// File: rtl/i2c_mem_slave.sv
// -----------------------------------------------------------------------------
// i2c_mem_slave
// I2C target with an on-chip byte memory. Write transfer: address+W, pointer
// byte, then data bytes stored at the pointer with auto-increment. Read
// transfer: address+R, then bytes returned from the current pointer with
// auto-increment until the master NACKs. No clock stretching.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (memory contents are not reset)
//   bus   i2c_mem_slave_if.slave: scl in; busy, write/read strobes, ack_err,
//         debug state out
//   sda   open-drain data pin: driven 0 when sda_low, otherwise released
// -----------------------------------------------------------------------------
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         MEM_DEPTH  = 256,
    parameter int         SDA_DELAY  = 4
) (
    input  logic           clk,
    input  logic           rst,
    i2c_mem_slave_if.slave bus,
    inout  wire            sda
);

    localparam int PW = $clog2(MEM_DEPTH);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync #(.SDA_DELAY(SDA_DELAY)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (bus.scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    slave_state_t    state_q, state_d;
    logic [3:0]      bit_q, bit_d;      // 7..0 while shifting; 8 = read byte loaded, not yet driven
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      tx_q, tx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            ack_phase_q, ack_phase_d;  // 1 while the ACK bit is being driven
    logic            sda_low_q, sda_low_d;
    logic            busy_q, busy_d;
    logic            ack_err_q, ack_err_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic            rd_strobe_q, rd_strobe_d;
    logic [7:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            mem_we;
    logic [7:0]      byte_in;
    logic [PW-1:0]   ptr_inc;
    logic [7:0]      rd_byte_cur, rd_byte_nxt;

    logic [7:0] mem [MEM_DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MEM_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign byte_in     = {shift_q[6:0], sda_s};
    assign ptr_inc     = next_ptr(ptr_q);
    assign rd_byte_cur = mem[ptr_q];
    assign rd_byte_nxt = mem[ptr_inc];

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;
        ack_err_d   = ack_err_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;

        // Bus conditions override any data event in the same cycle.
        if (stop) begin
            state_d     = IDLE;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
            ack_phase_d = 1'b0;
        end else if (start) begin
            state_d     = ADDR;
            bit_d       = 4'd7;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
            ack_err_d   = 1'b0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_q == 4'd0) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            state_d     = ADDR_ACK;
                            busy_d      = 1'b1;
                            rw_d        = byte_in[0];
                            ack_phase_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end

                ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_low_d   = (ACK == 1'b0);
                        ack_phase_d = 1'b1;
                    end else begin
                        ack_phase_d = 1'b0;
                        bit_d       = 4'd7;
                        sda_low_d   = 1'b0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            // First read bit goes out on the edge that ends the ACK.
                            tx_d        = rd_byte_cur;
                            rd_strobe_d = 1'b1;
                            sda_low_d   = ~rd_byte_cur[7];
                            state_d     = RD_DATA;
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end

                PTR: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_q == 4'd0) begin
                        ptr_d   = byte_in[PW-1:0];
                        state_d = PTR_ACK;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end

                WR_DATA: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_q == 4'd0) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = 8'(ptr_q);
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_inc;
                        state_d     = WR_ACK;
                    end else begin
                        bit_d = bit_q - 4'd1;
                    end
                end

                RD_DATA: if (scl_fall) begin
                    if (bit_q == 4'd0) begin
                        sda_low_d = 1'b0;
                        state_d   = RD_ACK;
                    end else begin
                        bit_d     = bit_q - 4'd1;
                        sda_low_d = ~tx_q[3'(bit_q - 4'd1)];
                    end
                end

                RD_ACK: if (scl_rise) begin
                    if (sda_s == NACK) begin
                        state_d = IDLE_WAIT;
                    end else begin
                        // Byte is loaded now but only driven from the next scl fall.
                        ptr_d       = ptr_inc;
                        tx_d        = rd_byte_nxt;
                        rd_strobe_d = 1'b1;
                        bit_d       = 4'd8;
                        state_d     = RD_DATA;
                        if (ptr_inc == '0) ack_err_d = 1'b1;
                    end
                end

                default: ;  // IDLE, IDLE_WAIT: only START/STOP move the FSM
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= 4'd7;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
            ack_err_q   <= ack_err_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Gated by rst so an in-flight byte is never committed during reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[ptr_q] <= byte_in;
    end

    assign sda           = sda_low_q ? 1'b0 : 1'bz;
    assign bus.busy      = busy_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
module tb_i2c_mem_slave;
    import i2c_pkg::*;

    localparam int Q = 25;  // quarter scl period in clk cycles

    logic clk;
    logic rst;
    logic m_low;
    wire  sda;

    i2c_mem_slave_if bus_if ();

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_mem_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .sda (sda)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt = 0;
    int exp_rd_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every committed write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (!rst && bus_if.wr_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h with nothing expected",
                         bus_if.wr_addr, bus_if.wr_data);
            end else begin
                check("wr_event", {16'h0, bus_if.wr_addr, bus_if.wr_data}, {16'h0, exp_q.pop_front()});
            end
        end
        if (!rst && bus_if.rd_strobe) rd_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wait_clks(Q);
        bus_if.scl = 1'b1; wait_clks(Q);
        m_low = 1'b1; wait_clks(Q);
        bus_if.scl = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wait_clks(Q);
        bus_if.scl = 1'b1; wait_clks(Q);
        m_low = 1'b0; wait_clks(Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wait_clks(Q);
        bus_if.scl = 1'b1; wait_clks(2 * Q);
        bus_if.scl = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic acked;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; wait_clks(Q);
        bus_if.scl = 1'b1; wait_clks(Q);
        acked = (sda === 1'b0);
        wait_clks(Q);
        bus_if.scl = 1'b0; wait_clks(Q);
        check(name, {31'h0, acked}, {31'h0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic do_ack, input string name);
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; wait_clks(Q);
            bus_if.scl = 1'b1; wait_clks(Q);
            got[i] = sda;
            wait_clks(Q);
            bus_if.scl = 1'b0; wait_clks(Q);
        end
        m_low = do_ack; wait_clks(Q);
        bus_if.scl = 1'b1; wait_clks(2 * Q);
        bus_if.scl = 1'b0; wait_clks(Q);
        m_low = 1'b0;
        check(name, {24'h0, got}, {24'h0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        m_low = 1'b0;
        bus_if.scl = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2);

        check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
        check("rst_ack_err", {31'h0, bus_if.ack_err}, 32'h0);
        check("rst_wr_addr_data", {16'h0, bus_if.wr_addr, bus_if.wr_data}, 32'h0);
        check("rst_state", 32'(bus_if.state), 32'(IDLE));
        check("rst_sda", {31'h0, sda}, 32'h1);

        // Preload mem[0x12] so the third read byte has a known value.
        i2c_start();
        send_byte(8'hA0, 1'b1, "pre_addr_ack");
        send_byte(8'h12, 1'b1, "pre_ptr_ack");
        exp_q.push_back({8'h12, 8'h7E});
        send_byte(8'h7E, 1'b1, "pre_data_ack");
        i2c_stop();

        // Write 0x5A, 0xC3 at 0x10.
        i2c_start();
        send_byte(8'hA0, 1'b1, "wr_addr_ack");
        check("wr_busy", {31'h0, bus_if.busy}, 32'h1);
        send_byte(8'h10, 1'b1, "wr_ptr_ack");
        exp_q.push_back({8'h10, 8'h5A});
        send_byte(8'h5A, 1'b1, "wr_d0_ack");
        exp_q.push_back({8'h11, 8'hC3});
        send_byte(8'hC3, 1'b1, "wr_d1_ack");
        i2c_stop();
        check("wr_busy_after_stop", {31'h0, bus_if.busy}, 32'h0);
        check("wr_state_after_stop", 32'(bus_if.state), 32'(IDLE));

        // Read back from 0x10 via repeated START.
        i2c_start();
        send_byte(8'hA0, 1'b1, "rd_waddr_ack");
        send_byte(8'h10, 1'b1, "rd_ptr_ack");
        i2c_start();
        exp_rd_cnt += 3;
        send_byte(8'hA1, 1'b1, "rd_raddr_ack");
        read_byte(8'h5A, 1'b1, "rd_b0");
        read_byte(8'hC3, 1'b1, "rd_b1");
        read_byte(8'h7E, 1'b0, "rd_b2");
        i2c_stop();

        // Pointer held at 0x12 after the NACK.
        i2c_start();
        exp_rd_cnt += 1;
        send_byte(8'hA1, 1'b1, "ptr_hold_addr_ack");
        read_byte(8'h7E, 1'b0, "ptr_hold_b");
        i2c_stop();

        // Address mismatch.
        i2c_start();
        send_byte(8'hA2, 1'b0, "mismatch_no_ack");
        check("mismatch_busy", {31'h0, bus_if.busy}, 32'h0);
        check("mismatch_state", 32'(bus_if.state), 32'(IDLE));
        i2c_stop();

        // Pointer wrap on write.
        i2c_start();
        send_byte(8'hA0, 1'b1, "wrap_addr_ack");
        send_byte(8'hFF, 1'b1, "wrap_ptr_ack");
        exp_q.push_back({8'hFF, 8'h11});
        send_byte(8'h11, 1'b1, "wrap_d0_ack");
        exp_q.push_back({8'h00, 8'h22});
        send_byte(8'h22, 1'b1, "wrap_d1_ack");
        i2c_stop();

        // Read across the wrap: ACK past 0xFF sets ack_err.
        i2c_start();
        send_byte(8'hA0, 1'b1, "wrapr_waddr_ack");
        send_byte(8'hFF, 1'b1, "wrapr_ptr_ack");
        i2c_start();
        exp_rd_cnt += 2;
        send_byte(8'hA1, 1'b1, "wrapr_raddr_ack");
        check("wrapr_ack_err_before", {31'h0, bus_if.ack_err}, 32'h0);
        read_byte(8'h11, 1'b1, "wrapr_b0");
        read_byte(8'h22, 1'b0, "wrapr_b1");
        i2c_stop();
        check("wrapr_ack_err_sticky", {31'h0, bus_if.ack_err}, 32'h1);

        // Abort mid-byte, then a normal write.
        i2c_start();
        check("start_clears_ack_err", {31'h0, bus_if.ack_err}, 32'h0);
        send_byte(8'hA0, 1'b1, "abort_addr_ack");
        send_byte(8'h30, 1'b1, "abort_ptr_ack");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        i2c_stop();
        check("abort_state", 32'(bus_if.state), 32'(IDLE));
        check("abort_busy", {31'h0, bus_if.busy}, 32'h0);
        i2c_start();
        send_byte(8'hA0, 1'b1, "post_abort_addr_ack");
        send_byte(8'h30, 1'b1, "post_abort_ptr_ack");
        exp_q.push_back({8'h30, 8'h96});
        send_byte(8'h96, 1'b1, "post_abort_data_ack");
        i2c_stop();

        // Reset during RD_DATA while the slave holds sda low (0x5A bit 7 = 0).
        i2c_start();
        send_byte(8'hA0, 1'b1, "rst_waddr_ack");
        send_byte(8'h10, 1'b1, "rst_ptr_ack");
        i2c_start();
        exp_rd_cnt += 1;
        send_byte(8'hA1, 1'b1, "rst_raddr_ack");
        check("rst_pre_state", 32'(bus_if.state), 32'(RD_DATA));
        check("rst_pre_sda_low", {31'h0, sda}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_sda_released", {31'h0, sda}, 32'h1);
        check("rst_mid_busy", {31'h0, bus_if.busy}, 32'h0);
        check("rst_mid_strobes", {30'h0, bus_if.wr_strobe, bus_if.rd_strobe}, 32'h0);
        check("rst_mid_ack_err", {31'h0, bus_if.ack_err}, 32'h0);
        check("rst_mid_wr_addr_data", {16'h0, bus_if.wr_addr, bus_if.wr_data}, 32'h0);
        check("rst_mid_state", 32'(bus_if.state), 32'(IDLE));
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        i2c_stop();
        wait_clks(10);

        check("wr_queue_empty", 32'(exp_q.size()), 32'h0);
        check("rd_strobe_count", 32'(rd_cnt), 32'(exp_rd_cnt));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
